// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store unit on a req/gnt/rvalid bus
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
package load_store_unit_pkg;
  typedef enum logic [3:0] {
    LS_N_A, S_B, S_H, S_W, L_B, L_H, L_W, L_BU, L_HU
  } load_store_type_e;
endpackage

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  input  load_store_type_e load_store_type_i,
  input  logic             write_enable_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  store_data_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [XLEN-1:0]  load_data_o,
  output logic             misalign_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]  load_data_q, load_data_d;
  logic             done_q, done_d;
  load_store_type_e type_q, type_d;
  logic [1:0]       off_q, off_d;

  logic             is_store, is_load, valid_req;
  logic [1:0]       off_i;
  logic [3:0]       be_i;
  logic [XLEN-1:0]  wdata_i;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [XLEN-1:0]  rd_ext;

  assign off_i     = addr_i[1:0];
  assign is_store  = load_store_type_i inside {S_B, S_H, S_W};
  assign is_load   = load_store_type_i inside {L_B, L_H, L_W, L_BU, L_HU};
  assign valid_req = req_valid_i && ((is_store && write_enable_i) || (is_load && !write_enable_i));

  // Halfword lane ignores off[0], so misaligned halves fall back to the aligned half.
  always_comb begin
    be_i    = 4'b1111;
    wdata_i = store_data_i;
    case (load_store_type_i)
      S_B, L_B, L_BU: begin
        be_i    = 4'b0001 << off_i;
        wdata_i = {4{store_data_i[7:0]}};
      end
      S_H, L_H, L_HU: begin
        be_i    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_i = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata_i[7:0];
    case (off_q)
      2'd1:    rd_byte = mem_rdata_i[15:8];
      2'd2:    rd_byte = mem_rdata_i[23:16];
      2'd3:    rd_byte = mem_rdata_i[31:24];
      default: ;
    endcase
    rd_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (type_q)
      L_B:     rd_ext = {{(XLEN-8){rd_byte[7]}}, rd_byte};
      L_BU:    rd_ext = {{(XLEN-8){1'b0}}, rd_byte};
      L_H:     rd_ext = {{(XLEN-16){rd_half[15]}}, rd_half};
      L_HU:    rd_ext = {{(XLEN-16){1'b0}}, rd_half};
      default: rd_ext = mem_rdata_i;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic misaligned_i;
  assign misaligned_i = ((load_store_type_i inside {S_H, L_H, L_HU}) && off_i[0]) ||
                        ((load_store_type_i inside {S_W, L_W}) && (off_i != 2'b00));
  assign misalign_o   = misalign_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) misalign_q <= 1'b0;
    else          misalign_q <= misalign_d;
  end
`else
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
    type_d      = type_q;
    off_d       = off_q;
    done_d      = 1'b0;
    stall_o     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (valid_req) begin
          stall_o     = 1'b1;
          type_d      = load_store_type_i;
          off_d       = off_i;
          mem_we_d    = is_store;
          mem_addr_d  = {addr_i[XLEN-1:2], 2'b00};
          mem_be_d    = be_i;
          mem_wdata_d = wdata_i;
          mem_req_d   = 1'b1;
          state_d     = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned_i) begin
            mem_req_d  = 1'b0;
            done_d     = 1'b1;
            misalign_d = 1'b1;
            state_d    = DONE;
          end
`endif
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          load_data_d = rd_ext;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      load_data_q <= '0;
      done_q      <= 1'b0;
      type_q      <= LS_N_A;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
      done_q      <= done_d;
      type_q      <= type_d;
      off_q       <= off_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign load_data_o = load_data_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             req_valid_i = 1'b0;
  load_store_type_e load_store_type_i = LS_N_A;
  logic             write_enable_i = 1'b0;
  logic [31:0]      addr_i = '0;
  logic [31:0]      store_data_i = '0;
  logic             stall_o, done_o, misalign_o, mem_req_o, mem_we_o;
  logic [31:0]      load_data_o, mem_addr_o, mem_wdata_o;
  logic [3:0]       mem_be_o;
  logic             mem_gnt_i = 1'b0;
  logic             mem_rvalid_i = 1'b0;
  logic [31:0]      mem_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  // Observations recorded by run_access
  int          d_cyc, pulses, sdrop, reqc;
  logic [31:0] r_addr, r_wdata, d_data;
  logic [3:0]  r_be;
  logic        r_we, d_mis, d_stall;

  load_store_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i),
    .load_store_type_i(load_store_type_i), .write_enable_i(write_enable_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .stall_o(stall_o), .done_o(done_o),
    .load_data_o(load_data_o), .misalign_o(misalign_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Drives one access with a simple bus model; gd = grant delay in REQ cycles, rd = rvalid delay after grant.
  task automatic run_access(input load_store_type_e t, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input int gd, input int rd, input logic [31:0] rdat);
    int req_cnt = 0;
    int rsp_cnt = 0;
    bit pend = 0;
    bit granted;
    req_valid_i = 1'b1; load_store_type_i = t; write_enable_i = we;
    addr_i = a; store_data_i = d; mem_rdata_i = rdat;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    d_cyc = -1; pulses = 0; sdrop = 0; reqc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (done_o === 1'b1) begin
        pulses++;
        if (d_cyc < 0) begin
          d_cyc = cyc; d_data = load_data_o; d_mis = misalign_o; d_stall = stall_o;
        end
      end else if (d_cyc < 0 && stall_o !== 1'b1) begin
        sdrop++;
      end
      if (mem_req_o === 1'b1) begin
        if (reqc == 0) begin
          r_addr = mem_addr_o; r_wdata = mem_wdata_o; r_be = mem_be_o; r_we = mem_we_o;
        end
        reqc++;
      end
      if (d_cyc >= 0 && cyc > d_cyc) break;
      granted = mem_req_o && mem_gnt_i;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      mem_gnt_i = mem_req_o && (req_cnt >= gd);
      if (mem_req_o) req_cnt++;
      if (granted && !we) begin pend = 1; rsp_cnt = 0; end
      mem_rvalid_i = 1'b0;
      if (pend) begin
        if (rsp_cnt >= rd) begin mem_rvalid_i = 1'b1; pend = 0; end
        rsp_cnt++;
      end
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if ({stall_o, done_o, misalign_o, mem_req_o, mem_we_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {stall_o, done_o, misalign_o, mem_req_o, mem_we_o}); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
    checks++; if (mem_be_o !== 4'h0) begin errors++; $display("FAIL reset_be: got %b expected 0000", mem_be_o); end
    checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata_o); end
    checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL reset_load_data: got %h expected 0", load_data_o); end
    @(negedge clk_i); rst_n_i = 1'b1;
    @(posedge clk_i); #2;
  endtask

  task automatic test_byte_store();
    run_access(S_B, 1'b1, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 32'h0);
    checks++; if (r_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h expected 00001000", r_addr); end
    checks++; if (r_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", r_be); end
    checks++; if (r_wdata !== 32'hDDDD_DDDD) begin errors++; $display("FAIL sb_wdata: got %h expected dddddddd", r_wdata); end
    checks++; if (r_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b expected 1", r_we); end
    checks++; if (d_cyc != 2) begin errors++; $display("FAIL sb_latency: got %0d expected 2", d_cyc); end
    checks++; if (pulses != 1 || sdrop != 0 || reqc != 1) begin
      errors++; $display("FAIL sb_handshake: pulses %0d stall_drops %0d req_cycles %0d expected 1 0 1", pulses, sdrop, reqc); end
    checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL sb_done_stall: got %b expected 0", d_stall); end
    checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL sb_load_data: got %h expected 0", load_data_o); end
  endtask

  task automatic test_byte_loads();
    run_access(L_B, 1'b0, 32'h0000_2001, 32'h0, 0, 0, 32'h1234_8056);
    checks++; if (d_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", d_data); end
    checks++; if (d_cyc != 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", d_cyc); end
    checks++; if (r_we !== 1'b0 || r_addr !== 32'h0000_2000) begin
      errors++; $display("FAIL lb_bus: we %b addr %h expected 0 00002000", r_we, r_addr); end
    run_access(L_BU, 1'b0, 32'h0000_2001, 32'h0, 0, 0, 32'h1234_8056);
    checks++; if (d_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", d_data); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL lbu_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_store_keeps_load_data();
    run_access(S_W, 1'b1, 32'h0000_2004, 32'h0102_0304, 1, 0, 32'hFFFF_FFFF);
    checks++; if (r_be !== 4'b1111 || r_wdata !== 32'h0102_0304) begin
      errors++; $display("FAIL sw_bus: be %b wdata %h expected 1111 01020304", r_be, r_wdata); end
    checks++; if (d_data !== 32'h0000_0080) begin errors++; $display("FAIL sw_keeps_load: got %h expected 00000080", d_data); end
    checks++; if (d_cyc != 3 || reqc != 2) begin
      errors++; $display("FAIL sw_gnt_delay: done %0d req_cycles %0d expected 3 2", d_cyc, reqc); end
  endtask

  task automatic test_halfword_slow();
    run_access(L_H, 1'b0, 32'h0000_2002, 32'h0, 3, 2, 32'h9ABC_0000);
    checks++; if (d_data !== 32'hFFFF_9ABC) begin errors++; $display("FAIL lh_data: got %h expected ffff9abc", d_data); end
    checks++; if (sdrop != 0) begin errors++; $display("FAIL lh_stall: got %0d drops expected 0", sdrop); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL lh_pulses: got %0d expected 1", pulses); end
    checks++; if (reqc != 4 || d_cyc != 8) begin
      errors++; $display("FAIL lh_timing: req_cycles %0d done %0d expected 4 8", reqc, d_cyc); end
    checks++; if (r_be !== 4'b1100) begin errors++; $display("FAIL lh_be: got %b expected 1100", r_be); end
  endtask

  task automatic test_ignored_requests();
    load_store_type_e tl[4] = '{L_W, LS_N_A, LS_N_A, S_B};
    logic             wl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1; load_store_type_i = tl[i]; write_enable_i = wl[i]; addr_i = 32'h10;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL ign_stall_%0d: got %b expected 0", i, stall_o); end
      @(posedge clk_i); #1;
      checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
        errors++; $display("FAIL ign_req_%0d: req %b stall %b expected 0 0", i, mem_req_o, stall_o); end
    end
    req_valid_i = 1'b1; load_store_type_i = S_W; write_enable_i = 1'b1;
    addr_i = 32'h40; store_data_i = 32'h1111_1111; mem_gnt_i = 1'b0;
    @(posedge clk_i); #1;
    load_store_type_i = S_B; addr_i = 32'h55; store_data_i = 32'h22;
    @(posedge clk_i); #1;
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40 || mem_wdata_o !== 32'h1111_1111 || mem_be_o !== 4'b1111) begin
      errors++; $display("FAIL ign_in_req: req %b addr %h wdata %h be %b expected 1 00000040 11111111 1111",
                         mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o); end
    req_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL ign_done: got %b expected 1", done_o); end
    repeat (2) @(posedge clk_i); #1;
    checks++; if (mem_req_o !== 1'b0 || done_o !== 1'b0 || mem_addr_o !== 32'h40) begin
      errors++; $display("FAIL ign_after: req %b done %b addr %h expected 0 0 00000040", mem_req_o, done_o, mem_addr_o); end
  endtask

  task automatic test_misaligned_word();
    run_access(L_W, 1'b0, 32'h0000_3002, 32'h0, 0, 0, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (reqc != 0) begin errors++; $display("FAIL mis_req: got %0d req cycles expected 0", reqc); end
    checks++; if (d_cyc != 1 || d_mis !== 1'b1) begin
      errors++; $display("FAIL mis_done: done %0d misalign %b expected 1 1", d_cyc, d_mis); end
    checks++; if (d_data !== 32'hFFFF_9ABC) begin errors++; $display("FAIL mis_data: got %h expected ffff9abc", d_data); end
`else
    checks++; if (r_addr !== 32'h0000_3000 || r_be !== 4'b1111) begin
      errors++; $display("FAIL mis_bus: addr %h be %b expected 00003000 1111", r_addr, r_be); end
    checks++; if (d_mis !== 1'b0 || misalign_o !== 1'b0) begin errors++; $display("FAIL mis_flag: got %b expected 0", d_mis); end
    checks++; if (d_data !== 32'hCAFE_F00D || d_cyc != 3) begin
      errors++; $display("FAIL mis_data: data %h done %0d expected cafef00d 3", d_data, d_cyc); end
`endif
  endtask

  task automatic test_reset_mid_load();
    int seen = 0;
    req_valid_i = 1'b1; load_store_type_i = L_W; write_enable_i = 1'b0; addr_i = 32'h50; mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    checks++; if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL rst_rsp: stall %b req %b expected 1 0", stall_o, mem_req_o); end
    #1 rst_n_i = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL rst_async: stall %b req %b expected 0 0", stall_o, mem_req_o); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk_i); rst_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (done_o === 1'b1 || mem_req_o === 1'b1) seen++;
    end
    mem_rvalid_i = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_no_done: got %0d active cycles expected 0", seen); end
    checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL rst_load_data: got %h expected 0", load_data_o); end
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_byte_loads();
    test_store_keeps_load_data();
    test_halfword_slow();
    test_ignored_requests();
    test_misaligned_word();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
